// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver (optional parity) feeding a byte FIFO with a valid/ready read port
// Ports: clk, rst_n (async, active-low); tx_rx_enable gates reception; rx_in serial line (idles high);
// rd_ready pops the FIFO head; rx_received_data/valid present the head; busy = frame in progress;
// frame_err/parity_err/overrun are single-cycle event pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_rx_enable,
  input  logic       rx_in,
  input  logic       rd_ready,
  output logic [7:0] rx_received_data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SMP_A = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP_B = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_C = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] CMAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state;
  logic          sync1, sync2, hist;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          smp_a, smp_b, perr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fall, decide, bit_val, full, pop, push;
  assign fall    = hist & ~sync2;
  assign decide  = cnt == SMP_C;
  // third sample is the live synchronized line at the decision point
  assign bit_val = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
  assign full    = count == FULL;
  assign valid   = count != '0;
  assign pop     = valid & rd_ready;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the byte
  assign push    = tx_rx_enable && state == STOP && decide && bit_val && !perr && (!full || pop);
  assign busy    = state != IDLE;
  assign rx_received_data = valid ? mem[rptr] : 8'h00;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= shreg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      hist       <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      perr       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      sync1      <= rx_in;
      sync2      <= sync1;
      hist       <= sync2;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      // cell counter is phase-locked to the falling edge that started the frame
      cnt <= (state == IDLE || cnt == CMAX) ? '0 : cnt + CW'(1);
      if (cnt == SMP_A) smp_a <= sync2;
      if (cnt == SMP_B) smp_b <= sync2;
      if (!tx_rx_enable) state <= IDLE;
      else
        case (state)
          IDLE:
            if (fall) begin
              state   <= START;
              perr    <= 1'b0;
              bit_cnt <= '0;
            end
          START:
            if (decide) state <= bit_val ? IDLE : DATA;
          DATA:
            if (decide) begin
              shreg   <= {bit_val, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          PARITY:
            if (decide) begin
              perr  <= bit_val != ((^shreg) ^ (PARITY_ODD != 0));
              state <= STOP;
            end
          STOP:
            // leave mid-stop-bit so a back-to-back start edge is not missed
            if (decide) begin
              state      <= IDLE;
              frame_err  <= !bit_val;
              parity_err <= bit_val && perr;
              overrun    <= bit_val && !perr && full && !pop;
            end
          default: state <= IDLE;
        endcase
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed checks of uart_rx_fifo against a queue-based frame model
module tb_uart_rx_fifo;
  logic clk = 0, rst_n = 0, en = 1;
  logic rx_in = 1, rdy = 0, rx_p = 1, rdy_p = 0;
  logic [7:0] data, data_p;
  logic valid, busy, frame_err, parity_err, overrun;
  logic valid_p, busy_p, frame_err_p, parity_err_p, overrun_p;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int fe_c[2], pe_c[2], ov_c[2];
  int busy_at = -1, valid_at = -1;
  logic busy_q = 0, valid_q = 0;
  logic [7:0] q[2][$];
  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .tx_rx_enable(en), .rx_in(rx_in), .rd_ready(rdy),
    .rx_received_data(data), .valid(valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );
  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .tx_rx_enable(1'b1), .rx_in(rx_p), .rd_ready(rdy_p),
    .rx_received_data(data_p), .valid(valid_p), .busy(busy_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    fe_c[0] += int'(frame_err);
    pe_c[0] += int'(parity_err);
    ov_c[0] += int'(overrun);
    fe_c[1] += int'(frame_err_p);
    pe_c[1] += int'(parity_err_p);
    ov_c[1] += int'(overrun_p);
    if (busy && !busy_q) busy_at = cyc;
    if (valid && !valid_q) valid_at = cyc;
    busy_q = busy;
    valid_q = valid;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      fe_c[i] = 0;
      pe_c[i] = 0;
      ov_c[i] = 0;
    end
  endtask
  task automatic drive(input bit p, input bit v, input int n);
    if (p) rx_p = v; else rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input bit p, input logic [7:0] b, input bit stop_bit, input bit par_bit, input int gap);
    drive(p, 0, 16);
    for (int i = 0; i < 8; i++) drive(p, b[i], 16);
    if (p) drive(p, par_bit, 16);
    drive(p, stop_bit, 16);
    if (gap > 0) drive(p, 1, gap);
  endtask
  task automatic pop_chk(input bit p, input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, p ? valid_p : valid, 1);
    chk({tag, "_data"}, p ? data_p : data, exp);
    if (p) rdy_p = 1; else rdy = 1;
    @(posedge clk);
    #1;
    rdy = 0;
    rdy_p = 0;
  endtask
  // model: frame error wins over parity error; a good byte into a full FIFO is dropped
  task automatic model(input bit p, input logic [7:0] b, input bit stop_bit, input bit par_bit,
                       inout int fe, inout int pe, inout int ov);
    if (!stop_bit) fe++;
    else if (p && par_bit != ^b) pe++;
    else if (q[p].size() == 4) ov++;
    else q[p].push_back(b);
  endtask
  initial begin
    int cs, fe, pe, ov, n, gap;
    logic [7:0] b;
    bit sb, pb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_err, parity_err, overrun}, 0);
    rst_n = 1;
    drive(0, 1, 5);
    clr();
    cs = cyc;
    send(0, 8'hA5, 1, 0, 16);
    chk("a5_busy_lat", (busy_at - cs >= 2) && (busy_at - cs <= 4), 1);
    chk("a5_valid_lat", (valid_at - cs >= 154) && (valid_at - cs <= 157), 1);
    chk("a5_flags", fe_c[0] + pe_c[0] + ov_c[0], 0);
    pop_chk(0, "a5", 8'hA5);
    chk("a5_empty", valid, 0);
    clr();
    busy_at = -1;
    cs = cyc;
    drive(0, 0, 4);
    drive(0, 1, 11);
    chk("glitch_busy_seen", busy_at >= cs, 1);
    chk("glitch_busy_end", busy, 0);
    drive(0, 1, 20);
    chk("glitch_valid", valid, 0);
    chk("glitch_flags", fe_c[0] + pe_c[0] + ov_c[0], 0);
    clr();
    send(0, 8'h3C, 0, 0, 24);
    chk("ferr_count", fe_c[0], 1);
    chk("ferr_valid", valid, 0);
    send(0, 8'h81, 1, 0, 20);
    pop_chk(0, "after_ferr", 8'h81);
    chk("ferr_only_one", fe_c[0] + pe_c[0] + ov_c[0], 1);
    clr();
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 1, 0, 0);
    chk("ovr_before5", ov_c[0], 0);
    send(0, 8'h05, 1, 0, 20);
    chk("ovr_on5", ov_c[0], 1);
    for (int i = 1; i <= 4; i++) pop_chk(0, "drain", 8'(i));
    chk("drain_empty", valid, 0);
    clr();
    send(1, 8'h07, 1, 1, 20);
    pop_chk(1, "par_good", 8'h07);
    send(1, 8'h07, 1, 0, 20);
    chk("par_err", pe_c[1], 1);
    chk("par_nopush", valid_p, 0);
    chk("par_noferr", fe_c[1], 0);
    clr();
    send(0, 8'h11, 1, 0, 20);
    drive(0, 0, 16);
    drive(0, 1, 16);
    drive(0, 0, 8);
    chk("en_busy_mid", busy, 1);
    en = 0;
    drive(0, 0, 2);
    chk("en_abort_busy", busy, 0);
    chk("en_keep_data", data, 8'h11);
    drive(0, 1, 20);
    en = 1;
    drive(0, 1, 200);
    chk("en_no_flags", fe_c[0] + pe_c[0] + ov_c[0], 0);
    pop_chk(0, "en_keep", 8'h11);
    chk("en_empty", valid, 0);
    send(0, 8'h22, 1, 0, 0);
    send(0, 8'h33, 1, 0, 20);
    drive(0, 0, 16);
    for (int i = 0; i < 4; i++) drive(0, i[0], 16);
    drive(0, 1, 8);
    chk("mid_busy", busy, 1);
    chk("mid_two_bytes", valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive(0, 1, 20);
    send(0, 8'h5A, 1, 0, 20);
    pop_chk(0, "post_rst", 8'h5A);
    chk("post_rst_empty", valid, 0);
    for (int r = 0; r < 8; r++) begin
      bit p;
      p = r[0];
      clr();
      fe = 0;
      pe = 0;
      ov = 0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        sb = $urandom_range(0, 4) != 0;
        pb = (^b) ^ ($urandom_range(0, 3) == 0);
        gap = sb ? 8 * $urandom_range(0, 3) : 20;
        model(p, b, sb, pb, fe, pe, ov);
        send(p, b, sb, pb, gap);
      end
      drive(p, 1, 20);
      chk("rnd_ferr", fe_c[p], fe);
      chk("rnd_perr", pe_c[p], pe);
      chk("rnd_ovr", ov_c[p], ov);
      while (q[p].size() > 0) pop_chk(p, "rnd_pop", q[p].pop_front());
      chk("rnd_empty", p ? valid_p : valid, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Standalone UART receiver. It is the receiving end for the serial stream produced by the team's UART transmitter (rx_in is driven by a peer's tx_out).
- Oversamples 8N1 frames (optional parity), validates the start bit by majority vote, and checks parity and stop bit.
- Good bytes are buffered in a small FIFO and presented on a valid/ready read port.
- Used in loopback benches and as the host-side receiver in system builds.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit cell; legal range 8..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, minimum 2.
- PARITY_EN, 0: 1 means a parity bit follows the 8 data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- tx_rx_enable  input  1  receiver enable; low aborts and holds the FSM in IDLE
- rx_in  input  1  asynchronous serial line, idles high
- rd_ready  input  1  consumer pops the FIFO head when valid && rd_ready
- rx_received_data  output  8  FIFO head byte; 0x00 when empty
- valid  output  1  FIFO not empty
- busy  output  1  frame in progress (FSM not IDLE)
- frame_err  output  1  1-cycle pulse: stop bit sampled 0
- parity_err  output  1  1-cycle pulse: parity mismatch
- overrun  output  1  1-cycle pulse: good byte dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE; bit counter, sample counter and FIFO pointers clear.
  - Synchronizer flops preset to 1.
  - rx_received_data=0x00; valid, busy, frame_err, parity_err, overrun = 0.
- Input path:
  - rx_in passes through a 2-flop synchronizer, then one history flop for edge detection.
  - Falling edge = history 1, synced 0.
- Sample points:
  - The sample counter counts 0..CLKS_PER_BIT-1 within each bit cell. H = CLKS_PER_BIT/2.
  - Samples are taken at cnt = H-1, H, H+1. The bit value is the majority of the three, decided at cnt = H+1.
- FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: on a falling edge with tx_rx_enable=1, go to START with cnt=0.
  - START: if the decision is 0, go to DATA. If the decision is 1 (glitch), return to IDLE with no flags.
  - DATA: 8 bits, LSB first, shifted into the shift register. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare the decision against the computed parity. On mismatch, latch an error flag for this frame.
  - STOP: on the decision, return to IDLE immediately (mid-stop-bit), so back-to-back frames are accepted.
    - Stop bit 0: pulse frame_err, discard the byte.
    - Stop bit 1 with the parity flag set: pulse parity_err, discard the byte.
    - Stop bit 1 with parity good: push the byte (or overrun, see FIFO).
- Frame-error recovery: after a frame error the line is low, so no new falling edge exists. A new start requires the line to return high first.
- Error precedence: frame_err is checked before parity_err. Exactly one error pulse per bad frame.
- FIFO:
  - A push is registered the cycle after the stop decision.
  - rx_received_data and valid update the cycle after a push into an empty FIFO.
  - A pop takes effect on the clk edge where valid && rd_ready.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push while full without a pop: byte dropped, overrun pulses, contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (state != IDLE).
- tx_rx_enable low:
  - The FSM enters IDLE on the next edge; any in-flight frame is discarded with no flags.
  - FIFO contents are retained and remain readable.
- Reset mid-frame: everything clears, including the FIFO. A partially received frame is never pushed.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless noted):
- Send 0xA5 (8N1, 16 clks/bit), rd_ready=0:
  - busy rises 3±1 cycles after the rx_in fall.
  - valid rises 154..157 cycles after the fall with rx_received_data=0xA5.
  - No error pulses.
- Drive rx_in low for 4 cycles, then high:
  - busy rises, then returns to 0 by cycle ~13.
  - valid stays 0, no flags.
- Send 0x3C with a stop bit of 0:
  - Exactly one frame_err pulse, valid stays 0.
  - After the line idles high, a following 0x81 is received correctly.
- Send 5 back-to-back bytes 0x01..0x05 with rd_ready=0:
  - overrun pulses once, on the 5th byte.
  - Draining with rd_ready=1 yields 0x01, 0x02, 0x03, 0x04, then valid=0.
- PARITY_EN=1, PARITY_ODD=0:
  - 0x07 with parity bit 1 is accepted.
  - 0x07 with parity bit 0 gives one parity_err pulse and no push.
- Deassert rst_n during data bit 4, with 2 bytes in the FIFO:
  - All outputs go to 0 immediately, FIFO empty.
  - The next full frame 0x5A is received normally.
